// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock through a
// BUS_WIDTH+1-bit subtractor, with a start/done handshake.
module restoring_divider #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] out,
  output logic [BUS_WIDTH-1:0] remainder,
  output logic                 div_by_zero,
  output logic [1:0]           state_dbg
);

  // Handshake: start is taken only in IDLE (that edge is the accept edge and
  // latches in1/in2); done is a one-cycle pulse marking out/remainder/div_by_zero
  // valid, and those results hold until the next done. Start in RUN/DONE is dropped.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int             CW   = $clog2(BUS_WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(BUS_WIDTH - 1);

  logic [1:0]           state;
  logic [BUS_WIDTH-1:0] quo;
  logic [BUS_WIDTH-1:0] dvsr;
  logic [BUS_WIDTH-1:0] prem;
  logic [CW-1:0]        cnt;

  logic [BUS_WIDTH:0]   shifted;
  logic [BUS_WIDTH:0]   trial;
  logic [BUS_WIDTH-1:0] prem_next;
  logic [BUS_WIDTH-1:0] quo_next;

  assign state_dbg = state;

  // The kept partial remainder is always below the divisor, so it fits in
  // BUS_WIDTH bits; the extra bit only exists in the shifted/trial values.
  always_comb begin
    shifted = {prem, quo[BUS_WIDTH-1]};
    trial   = shifted - {1'b0, dvsr};
    if (!trial[BUS_WIDTH]) begin
      prem_next = trial[BUS_WIDTH-1:0];
      quo_next  = {quo[BUS_WIDTH-2:0], 1'b1};
    end else begin
      prem_next = shifted[BUS_WIDTH-1:0];
      quo_next  = {quo[BUS_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      quo         <= '0;
      dvsr        <= '0;
      prem        <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      out         <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            quo  <= in1;
            dvsr <= in2;
            prem <= '0;
            cnt  <= '0;
            if (in2 == '0) begin
              state       <= ST_DONE;
              done        <= 1'b1;
              out         <= '1;
              remainder   <= in1;
              div_by_zero <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          quo  <= quo_next;
          prem <= prem_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            state       <= ST_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            out         <= quo_next;
            remainder   <= prem_next;
            div_by_zero <= 1'b0;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Bench for restoring_divider: cycle-level arithmetic model on a 32-bit instance,
// plus an expected-queue scoreboard on an 8-bit instance.
module tb_restoring_divider;

  localparam int W  = 32;
  localparam int W8 = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  in1 = '0, in2 = '0;
  logic          busy, done, dbz;
  logic [W-1:0]  out, rem;
  logic [1:0]    st;

  logic          s8 = 1'b0;
  logic [W8-1:0] a8 = '0, b8 = '0;
  logic          busy8, done8, dbz8;
  logic [W8-1:0] out8, rem8;
  logic [1:0]    st8;

  restoring_divider #(.BUS_WIDTH(W)) u_div32 (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .out(out), .remainder(rem),
    .div_by_zero(dbz), .state_dbg(st)
  );

  restoring_divider #(.BUS_WIDTH(W8)) u_div8 (
    .clk(clk), .rst(rst), .start(s8), .in1(a8), .in2(b8),
    .busy(busy8), .done(done8), .out(out8), .remainder(rem8),
    .div_by_zero(dbz8), .state_dbg(st8)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  logic [W8-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model of the 32-bit instance: a countdown to the result plus plain / and %
  int           m_left = 0;
  bit           m_done = 1'b0;
  bit           m_dbz = 1'b0;
  logic [W-1:0] m_out = '0, m_rem = '0, p_q = '0, p_r = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_out = '0; m_rem = '0; m_dbz = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_out = p_q; m_rem = p_r; m_dbz = 1'b0;
      end
    end else if (start) begin
      if (in2 == '0) begin
        m_done = 1'b1; m_out = '1; m_rem = in1; m_dbz = 1'b1;
      end else begin
        m_left = W; p_q = in1 / in2; p_r = in1 % in2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_left > 0));
      check("done", 64'(done), 64'(m_done));
      check("out", 64'(out), 64'(m_out));
      check("remainder", 64'(rem), 64'(m_rem));
      check("div_by_zero", 64'(dbz), 64'(m_dbz));
    end
  end

  // driver tasks
  task automatic run32(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    in1 = a; in2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in1 = $urandom; in2 = $urandom;
    lat = 1;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout32", 64'(lat), 64'(0));
    check("latency32", 64'(lat), (b == '0) ? 64'(1) : 64'(W + 1));
    @(negedge clk);
    check("done_one_cycle32", 64'(done), 64'(0));
  endtask

  task automatic run8(input logic [W8-1:0] a, input logic [W8-1:0] b);
    int lat;
    logic [W8-1:0] eq, er;
    @(negedge clk);
    a8 = a; b8 = b; s8 = 1'b1;
    if (b == '0) begin
      exp_q.push_back('1);
      exp_q.push_back(a);
    end else begin
      exp_q.push_back(a / b);
      exp_q.push_back(a % b);
    end
    @(negedge clk);
    s8 = 1'b0; a8 = W8'($urandom_range(0, 255)); b8 = W8'($urandom_range(0, 255));
    lat = 1;
    while (!done8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    eq = exp_q.pop_front();
    er = exp_q.pop_front();
    if (!done8) begin
      check("done_timeout8", 64'(lat), 64'(0));
    end else begin
      check("out8", 64'(out8), 64'(eq));
      check("remainder8", 64'(rem8), 64'(er));
      check("div_by_zero8", 64'(dbz8), 64'(b == '0));
      check("busy8_at_done", 64'(busy8), 64'(0));
    end
    check("latency8", 64'(lat), (b == '0) ? 64'(1) : 64'(W8 + 1));
    @(negedge clk);
    check("done_one_cycle8", 64'(done8), 64'(0));
  endtask

  task automatic gen32(output logic [W-1:0] a, output logic [W-1:0] b);
    case ($urandom_range(0, 4))
      0: begin a = $urandom; b = $urandom; end
      1: begin a = $urandom; b = a; end
      2: begin a = W'($urandom_range(0, 1000)); b = a + W'($urandom_range(1, 1000)); end
      3: begin a = $urandom; b = W'($urandom_range(1, 15)); end
      default: begin a = $urandom; b = W'($urandom_range(0, 3)); end
    endcase
  endtask

  task automatic gen8(output logic [W8-1:0] a, output logic [W8-1:0] b);
    case ($urandom_range(0, 4))
      0: begin a = W8'($urandom_range(0, 255)); b = W8'($urandom_range(0, 255)); end
      1: begin a = W8'($urandom_range(0, 255)); b = a; end
      2: begin a = W8'($urandom_range(0, 100)); b = a + W8'($urandom_range(1, 100)); end
      3: begin a = W8'($urandom_range(0, 255)); b = W8'($urandom_range(1, 15)); end
      default: begin a = W8'($urandom_range(0, 255)); b = W8'($urandom_range(0, 3)); end
    endcase
  endtask

  initial begin
    int lat, ndone;
    logic [W-1:0] a, b;
    logic [W8-1:0] c, d;

    repeat (3) @(negedge clk);
    check("rst_out", 64'(out), 64'(0));
    check("rst_rem", 64'(rem), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dbz", 64'(dbz), 64'(0));
    check("rst_out8", 64'(out8), 64'(0));
    chk_en = 1'b1;
    rst = 1'b0;

    run32(32'd100, 32'd7, lat);
    check("lit_100_7_lat", 64'(lat), 64'(33));
    check("lit_100_7_q", 64'(out), 64'(14));
    check("lit_100_7_r", 64'(rem), 64'(2));
    check("lit_100_7_z", 64'(dbz), 64'(0));

    run32(32'd5, 32'd9, lat);
    check("lit_5_9_q", 64'(out), 64'(0));
    check("lit_5_9_r", 64'(rem), 64'(5));

    run32(32'hFFFF_FFFF, 32'd1, lat);
    check("lit_max_1_q", 64'(out), 64'hFFFF_FFFF);
    check("lit_max_1_r", 64'(rem), 64'(0));

    run32(32'd1234, 32'd0, lat);
    check("lit_dbz_lat", 64'(lat), 64'(1));
    check("lit_dbz_q", 64'(out), 64'hFFFF_FFFF);
    check("lit_dbz_r", 64'(rem), 64'(1234));
    check("lit_dbz_z", 64'(dbz), 64'(1));

    // start during RUN and during the DONE cycle must both be dropped
    @(negedge clk);
    in1 = 32'd100; in2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    in1 = 32'd50; in2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        in1 = 32'd9; in2 = 32'd0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("ignored_start_ndone", 64'(ndone), 64'(1));
    check("ignored_start_q", 64'(out), 64'(14));
    check("ignored_start_r", 64'(rem), 64'(2));

    // reset in the middle of RUN
    @(negedge clk);
    in1 = 32'd1000; in2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out", 64'(out), 64'(0));
    check("midrst_rem", 64'(rem), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'(0));
    run32(32'd1000, 32'd3, lat);
    check("lit_1000_3_q", 64'(out), 64'(333));
    check("lit_1000_3_r", 64'(rem), 64'(1));

    run8(8'd200, 8'd7);
    check("lit8_200_7_q", 64'(out8), 64'(28));
    check("lit8_200_7_r", 64'(rem8), 64'(4));

    for (int i = 0; i < 500; i++) begin
      gen32(a, b);
      run32(a, b, lat);
    end
    for (int i = 0; i < 500; i++) begin
      gen8(c, d);
      run8(c, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
